// File: rtl/present_iter_core.sv
// Iterative PRESENT encryption core, UNROLL rounds per clock, 80/128-bit key.
// Define PRESENT_ABORT_EN to add an abort input that cancels a running block.
module present_iter_core #(
  parameter int KEY_W  = 80,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PRESENT_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key
    $fatal(1, "present_iter_core: KEY_W must be 80 or 128");
  end
  if (UNROLL < 1 || UNROLL > 31) begin : g_bad_unroll
    $fatal(1, "present_iter_core: UNROLL must be 1..31");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Nibble n of SBOX_T is S(n).
  localparam logic [63:0] SBOX_T = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_T[4*x +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = sbox(s[4*n +: 4]);
    end
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    o[63] = s[63];
    for (int i = 0; i < 63; i++) begin
      o[(16*i) % 63] = s[i];
    end
    return o;
  endfunction

  function automatic logic [KEY_W-1:0] key_upd(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       r
  );
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
    if (KEY_W == 128) begin
      t[KEY_W-5 -: 4] = sbox(t[KEY_W-5 -: 4]);
      t[66:62] = t[66:62] ^ r;
    end else begin
      t[19:15] = t[19:15] ^ r;
    end
    return t;
  endfunction

  state_e           state_q, state_d;
  logic [63:0]      st_q, st_d;
  logic [KEY_W-1:0] kr_q, kr_d;
  logic [4:0]       rc_q, rc_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [63:0]      st_rnd;
  logic [KEY_W-1:0] kr_rnd;
  logic [5:0]       r6;
  logic [5:0]       rc_sum;
  logic             last;
  logic             accept;
  logic             abort_w;

`ifdef PRESENT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Stages past round 31 pass state and key through untouched.
  always_comb begin
    st_rnd = st_q;
    kr_rnd = kr_q;
    r6     = '0;
    for (int j = 0; j < UNROLL; j++) begin
      r6 = {1'b0, rc_q} + 6'(j);
      if (r6 <= 6'd31) begin
        st_rnd = p_layer(s_layer(st_rnd ^ kr_rnd[KEY_W-1 -: 64]));
        kr_rnd = key_upd(kr_rnd, r6[4:0]);
      end
    end
  end

  assign rc_sum   = {1'b0, rc_q} + 6'(UNROLL);
  assign last     = rc_sum > 6'd31;
  assign in_ready = (state_q == IDLE) ||
                    (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    kr_d        = kr_q;
    rc_d        = rc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
          rc_d    = 5'd1;
        end else if (last) begin
          out_data_d  = st_rnd ^ kr_rnd[KEY_W-1 -: 64];
          out_valid_d = 1'b1;
          state_d     = DONE;
          rc_d        = 5'd1;
        end else begin
          st_d = st_rnd;
          kr_d = kr_rnd;
          rc_d = rc_sum[4:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in DONE overrides the drop to IDLE (back-to-back).
    if (accept) begin
      st_d    = in_data;
      kr_d    = in_key;
      rc_d    = 5'd1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      kr_q        <= '0;
      rc_q        <= 5'd1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      kr_q        <= kr_d;
      rc_q        <= rc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/present_iter_core.md
Name: present_iter_core

Overview:
Parametrised, iterative PRESENT block-cipher encryption core. It processes one 64-bit block at a time through 31 rounds plus a final key whitening. UNROLL round stages are evaluated per clock, so area versus latency is a build-time choice. Key size is selectable between 80 and 128 bits. It has a valid/ready handshake on both sides, so it drops into the streaming datapath in place of the fully unrolled 31-stage pipeline.

Parameters:
KEY_W, 80, key length; only 80 or 128 are legal, anything else is a fatal elaboration error.
UNROLL, 1, rounds per clock, range 1..31. Cycles per block are N = ceil(31/UNROLL).

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  core can accept a block
in_data  in  64  plaintext
in_key  in  KEY_W  user key
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_data  out  64  ciphertext

Behaviour:
- FSM states: IDLE, RUN, DONE. Registers:
  - st (64)
  - kr (KEY_W)
  - rc (5-bit round counter, value 1..31; a separate 6-bit next value covers 32)
  - out_data (64)
- Reset (asynchronous, rst_n=0): FSM=IDLE, st=0, kr=0, rc=1, out_data=0, out_valid=0.
- Reset mid-operation aborts the block. No output is produced.
- in_ready = (FSM==IDLE) || (FSM==DONE && out_ready). This is combinational from out_ready.
- Accept occurs when in_valid && in_ready at an edge:
  - st <= in_data, kr <= in_key, rc <= 1, FSM <= RUN.
  - in_data and in_key are sampled only on that edge.
- Round stage j (0..UNROLL-1) applies round r = rc+j only if r <= 31; otherwise it passes data through:
  - st ^= kr[KEY_W-1 -: 64]
  - 4-bit S-box on all 16 nibbles (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2)
  - pLayer: bit i moves to (16*i) mod 63; bit 63 stays fixed
  - key update, 80-bit: rotate left 61; S-box bits[79:76]; bits[19:15] ^= r
  - key update, 128-bit: rotate left 61; S-box bits[127:124] and [123:120]; bits[66:62] ^= r
- Each RUN edge: rc <= rc+UNROLL. When rc+UNROLL > 31:
  - out_data <= st_after_stages ^ kr_after_stages[KEY_W-1 -: 64]
  - out_valid <= 1, FSM <= DONE
- Latency: out_valid rises exactly N edges after the accept edge (31 for UNROLL=1, 1 for UNROLL=31).
- DONE: out_valid and out_data are held stable until out_valid && out_ready.
  - Without a simultaneous accept: FSM <= IDLE, out_valid <= 0.
  - With a simultaneous accept (back-to-back): FSM <= RUN and the new block loads in the same edge. out_data keeps its old value until overwritten; the consumer must not sample it while out_valid=0.
- in_valid in RUN is ignored; in_ready is 0.
- Throughput: one block per N cycles with back-to-back handshakes.

Optional Feature:
PRESENT_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in RUN: FSM <= IDLE, rc <= 1, out_valid stays 0, and no ciphertext is emitted.
  - abort has priority over completion in the same edge.
  - abort in IDLE or DONE has no effect.
- Undefined: no abort port; a block, once accepted, always completes.

Test Plan:
1. KEY_W=80, UNROLL=1, in_data=0, in_key=0, out_ready=1 -> out_valid exactly 31 cycles after accept, out_data=64'h5579C1387B228445.
2. KEY_W=80, UNROLL=4, in_data=64'hFFFFFFFFFFFFFFFF, in_key=all ones -> out_data=64'h3333DCD3213210D2 after 8 cycles. Repeat with UNROLL=31 -> same value after 1 cycle.
3. KEY_W=128, in_data=0, in_key=0 -> out_data=64'h96DB702A2E6900AF. Check for every UNROLL in {1,2,8,31}.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 (key=all ones, data=0) -> new block accepted same edge, later output 64'hE72C46C0F5945049.
5. Assert rst_n=0 at cycle 15 of a UNROLL=1 block -> out_valid=0, in_ready=1 immediately. A fresh block after release gives the correct ciphertext.
6. With PRESENT_ABORT_EN: abort at cycle 5 of RUN -> no out_valid pulse, in_ready=1 the next cycle. abort in DONE -> output still delivered.
